// File: rtl/song_dump_tx.sv
// UART transmitter that streams the stored song back to the host: each 12-bit
// note word becomes two 8N1 bytes (high nibble first), followed by an end marker.
module song_dump_tx #(
    parameter int          CLK_FREQ = 100_000_000,
    parameter int          BAUD     = 9600,
    parameter int          ADDR_W   = 16,
    parameter logic [7:0]  END_MARK = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic              txd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_word
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, HI, LO, MARK, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, idx, idx_inc;
    logic [7:0]        word_lo;
    logic              fetch_wait;
    logic [TW-1:0]     timer;
    logic [3:0]        bit_cnt;
    logic [8:0]        shreg;
    logic              bit_end, byte_end, last_word, load;
    logic [7:0]        load_byte;

    assign bit_end   = (timer == TW'(DIV - 1));
    assign byte_end  = bit_end && (bit_cnt == 4'd9);
    assign idx_inc   = idx + ADDR_W'(1);
    assign last_word = (idx_inc == cnt);
    assign cur_word  = idx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A byte is loaded on the same edge that enters HI, LO or MARK, so the
    // start bit appears right away and consecutive bytes have no idle gap.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_byte  = END_MARK;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_next = MARK;
                        load       = 1'b1;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (fetch_wait) begin
                    state_next = HI;
                    load       = 1'b1;
                    load_byte  = {4'b0000, rd_data[11:8]};
                end
            end
            HI: begin
                if (byte_end) begin
                    state_next = LO;
                    load       = 1'b1;
                    load_byte  = word_lo;
                end
            end
            LO: begin
                if (byte_end) begin
                    if (last_word) begin
                        state_next = MARK;
                        load       = 1'b1;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            MARK: begin
                if (byte_end) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word sequencing: count is latched once per dump, rd_addr only advances
    // when another word is still to be fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            rd_addr    <= '0;
            word_lo    <= '0;
            fetch_wait <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= (state_next == DONE);
            fetch_wait <= (state == FETCH) && !fetch_wait;
            if (state == IDLE && start) begin
                cnt     <= count;
                idx     <= '0;
                rd_addr <= '0;
                busy    <= 1'b1;
            end
            if (state == FETCH && fetch_wait) word_lo <= rd_data[7:0];
            if (state == LO && byte_end) begin
                idx <= idx_inc;
                if (!last_word) rd_addr <= idx_inc;
            end
            if (state == DONE) busy <= 1'b0;
        end
    end

    // Serialiser: shreg holds the data bits and stop bit still to be sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd     <= 1'b1;
            shreg   <= '1;
            timer   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            txd     <= 1'b0;
            shreg   <= {1'b1, load_byte};
            timer   <= '0;
            bit_cnt <= '0;
        end else if (state inside {HI, LO, MARK}) begin
            if (bit_end) begin
                timer <= '0;
                if (bit_cnt != 4'd9) begin
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                timer <= timer + TW'(1);
            end
        end else begin
            txd   <= 1'b1;
            timer <= '0;
        end
    end

endmodule

// File: tb/tb_song_dump_tx.sv
// Scoreboard bench for song_dump_tx: expected bytes are queued by the stimulus,
// a line decoder and a done monitor pop and compare independently.
module tb_song_dump_tx;

    localparam int DIV = 10;

    typedef struct {
        logic [7:0]  data;
        logic        chkAddr;
        logic [15:0] addr;
        logic        chkWord;
        logic [15:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] count;
    logic [15:0] rdAddr;
    logic [11:0] rdData;
    logic        txd;
    logic        busy;
    logic        done;
    logic [15:0] curWord;

    logic [11:0] mem [0:15];
    exp_t        expQ [$];
    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rdData <= mem[rdAddr[3:0]];

    song_dump_tx #(
        .CLK_FREQ(1000),
        .BAUD    (100),
        .ADDR_W  (16),
        .END_MARK(8'hFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .count   (count),
        .rd_addr (rdAddr),
        .rd_data (rdData),
        .txd     (txd),
        .busy    (busy),
        .done    (done),
        .cur_word(curWord)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [7:0] d, input logic ca, input logic [15:0] a,
                           input logic cw, input logic [15:0] w);
        exp_t e;
        e.data = d; e.chkAddr = ca; e.addr = a; e.chkWord = cw; e.word = w;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [15:0] n);
        count = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int maxCycles);
        int n = 0;
        while (done !== 1'b1 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxCycles) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: done not seen within %0d clks", name, maxCycles);
        end
    endtask

    // Line decoder: mid-bit sampling, frames overlapping a reset are discarded.
    initial begin
        logic        prevTxd, sawRst, startBit, stopBit;
        logic [7:0]  rx;
        logic [15:0] addrAtStart, wordAtStart;
        exp_t        e;
        prevTxd = 1'b1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || !(prevTxd === 1'b1 && txd === 1'b0)) begin
                prevTxd = txd;
                continue;
            end
            sawRst = 1'b0;
            repeat (DIV / 2) begin
                @(negedge clk);
                if (rst) sawRst = 1'b1;
            end
            startBit    = txd;
            addrAtStart = rdAddr;
            wordAtStart = curWord;
            for (int b = 0; b < 8; b++) begin
                repeat (DIV) begin
                    @(negedge clk);
                    if (rst) sawRst = 1'b1;
                end
                rx[b] = txd;
            end
            repeat (DIV) begin
                @(negedge clk);
                if (rst) sawRst = 1'b1;
            end
            stopBit = txd;
            prevTxd = txd;
            if (!sawRst) begin
                checkOutput("start_bit", {31'd0, startBit}, 32'd0);
                checkOutput("stop_bit", {31'd0, stopBit}, 32'd1);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", rx);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("byte", {24'd0, rx}, {24'd0, e.data});
                    if (e.chkAddr) checkOutput("rd_addr", {16'd0, addrAtStart}, {16'd0, e.addr});
                    if (e.chkWord) checkOutput("cur_word", {16'd0, wordAtStart}, {16'd0, e.word});
                end
            end
        end
    end

    // Done monitor: every byte must be on the line before done, busy drops after.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneCount++;
                checkOutput("queue_empty_at_done", expQ.size(), 32'd0);
                @(negedge clk);
                checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        count = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_txd", {31'd0, txd}, 32'd1);
            checkOutput("reset_busy", {31'd0, busy}, 32'd0);
            checkOutput("reset_done", {31'd0, done}, 32'd0);
            checkOutput("reset_rd_addr", {16'd0, rdAddr}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_txd", {31'd0, txd}, 32'd1);
        checkOutput("post_reset_cur_word", {16'd0, curWord}, 32'd0);

        $display("[TB] single word");
        mem[0] = 12'hA5C;
        pushExp(8'h0A, 1, 16'd0, 1, 16'd0);
        pushExp(8'h5C, 1, 16'd0, 1, 16'd0);
        pushExp(8'hFF, 1, 16'd0, 0, 16'd0);
        d0 = doneCount;
        applyStimulus(16'd1);
        waitDone("single_word", 1000);
        repeat (20) @(negedge clk);
        checkOutput("single_done_count", doneCount - d0, 32'd1);

        $display("[TB] three words");
        mem[0] = 12'h123; mem[1] = 12'h456; mem[2] = 12'h789;
        pushExp(8'h01, 1, 16'd0, 1, 16'd0);
        pushExp(8'h23, 1, 16'd0, 1, 16'd0);
        pushExp(8'h04, 1, 16'd1, 1, 16'd1);
        pushExp(8'h56, 1, 16'd1, 1, 16'd1);
        pushExp(8'h07, 1, 16'd2, 1, 16'd2);
        pushExp(8'h89, 1, 16'd2, 1, 16'd2);
        pushExp(8'hFF, 1, 16'd2, 0, 16'd0);
        d0 = doneCount;
        applyStimulus(16'd3);
        waitDone("three_words", 2000);
        repeat (20) @(negedge clk);
        checkOutput("three_done_count", doneCount - d0, 32'd1);

        $display("[TB] empty dump");
        pushExp(8'hFF, 1, 16'd0, 0, 16'd0);
        d0 = doneCount;
        applyStimulus(16'd0);
        waitDone("empty_dump", 500);
        repeat (20) @(negedge clk);
        checkOutput("empty_done_count", doneCount - d0, 32'd1);
        checkOutput("empty_rd_addr", {16'd0, rdAddr}, 32'd0);

        $display("[TB] start and reset together");
        rst   = 1'b1;
        start = 1'b1;
        count = 16'd1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_wins_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("rst_wins_txd", {31'd0, txd}, 32'd1);
        checkOutput("rst_wins_busy_later", {31'd0, busy}, 32'd0);

        $display("[TB] start while busy");
        mem[0] = 12'hFED; mem[1] = 12'h001;
        pushExp(8'h0F, 1, 16'd0, 1, 16'd0);
        pushExp(8'hED, 1, 16'd0, 1, 16'd0);
        pushExp(8'h00, 1, 16'd1, 1, 16'd1);
        pushExp(8'h01, 1, 16'd1, 1, 16'd1);
        pushExp(8'hFF, 1, 16'd1, 0, 16'd0);
        d0 = doneCount;
        applyStimulus(16'd2);
        repeat (50) @(negedge clk);
        applyStimulus(16'd5);
        waitDone("busy_start", 2000);
        repeat (300) @(negedge clk);
        checkOutput("busy_start_done_count", doneCount - d0, 32'd1);
        checkOutput("busy_start_idle", {31'd0, busy}, 32'd0);

        $display("[TB] reset mid-byte");
        mem[0] = 12'h3C5;
        pushExp(8'h03, 1, 16'd0, 1, 16'd0);
        d0 = doneCount;
        applyStimulus(16'd1);
        repeat (2 + 10 * DIV + 35 - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_txd", {31'd0, txd}, 32'd1);
        checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("mid_reset_no_done", doneCount - d0, 32'd0);
        checkOutput("mid_reset_queue", expQ.size(), 32'd0);

        mem[0] = 12'h0B1;
        pushExp(8'h00, 1, 16'd0, 1, 16'd0);
        pushExp(8'hB1, 1, 16'd0, 1, 16'd0);
        pushExp(8'hFF, 1, 16'd0, 0, 16'd0);
        d0 = doneCount;
        applyStimulus(16'd1);
        waitDone("after_reset_frame", 1000);
        repeat (20) @(negedge clk);
        checkOutput("after_reset_done_count", doneCount - d0, 32'd1);
        checkOutput("final_queue", expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
